// File: rtl/sevenseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_ctrl_if
// Description : Signal bundle between the seven-segment register bank / pins
//               and the scan controller. The slave modport is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevenseg_scan_ctrl_if #(
   parameter int DIGITS = 8
);
   logic [7*DIGITS-1:0] sevenseg;     // active-low patterns, digit i at [7i+6:7i]
   logic [DIGITS-1:0]   digit_en;     // 0 keeps digit dark for its slot
   logic [3:0]          brightness;   // duty level 0..15
   logic [DIGITS-1:0]   an;           // active-low anode drive
   logic [6:0]          seg;          // active-low segment drive
   logic                frame_start;  // pulse after scan wraps to digit 0

   modport master (
      output sevenseg,
      output digit_en,
      output brightness,
      input  an,
      input  seg,
      input  frame_start
   );

   modport slave (
      input  sevenseg,
      input  digit_en,
      input  brightness,
      output an,
      output seg,
      output frame_start
   );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_ctrl
// Description : Time-multiplexed seven-segment scan controller. Each digit
//               slot starts with a blanking interval, followed by a PWM
//               on-window sized by the brightness level latched at slot start.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_ctrl #(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000,
   parameter int DEAD     = 64
) (
   input  wire logic               clk,
   input  wire logic               rst,
   sevenseg_scan_ctrl_if.slave     io_bus
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV) + 1;
   localparam int STEP  = (SCAN_DIV - DEAD) / 16;

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] c_DEAD     = CNT_W'(DEAD);
   localparam logic [CNT_W-1:0] c_STEP     = CNT_W'(STEP);
   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DIGITS - 1);

   // Reject parameter sets that cannot produce a well-formed slot.
   if ((SCAN_DIV <= DEAD) || (DEAD < 1) || (((SCAN_DIV - DEAD) % 16) != 0)) begin : g_bad_params
      $error("sevenseg_scan_ctrl: illegal SCAN_DIV/DEAD combination");
   end

   typedef enum logic [1:0] {
      PH_BLANK = 2'd0,
      PH_ON    = 2'd1,
      PH_OFF   = 2'd2
   } phase_t;

   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [3:0]        r_bright_q;
   logic [DIGITS-1:0] r_an;
   logic [6:0]        r_seg;
   logic              r_frame_start;

   logic [CNT_W-1:0]  w_on_len;
   logic [CNT_W-1:0]  w_on_end;
   logic              w_slot_last;
   logic              w_digit_en;
   logic [6:0]        w_seg_sel;
   phase_t            w_phase;

   // The on-window length never exceeds SCAN_DIV-DEAD, so CNT_W bits hold it.
   assign w_on_len    = (CNT_W'(r_bright_q) + CNT_W'(1)) * c_STEP;
   assign w_on_end    = c_DEAD + w_on_len;
   assign w_slot_last = (r_cnt == c_CNT_LAST);
   assign w_digit_en  = io_bus.digit_en[r_idx];
   assign w_seg_sel   = io_bus.sevenseg[r_idx*7 +: 7];

   // Slot counter, digit index and per-slot brightness latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_bright_q <= '0;
      end else begin
         if (r_cnt == '0) begin
            r_bright_q <= io_bus.brightness;
         end
         if (w_slot_last) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Phase decode: blanking first, then the brightness window if enabled.
   always_comb begin
      w_phase = PH_OFF;
      if (r_cnt < c_DEAD) begin
         w_phase = PH_BLANK;
      end else if ((r_cnt < w_on_end) && w_digit_en) begin
         w_phase = PH_ON;
      end
   end

   // Registered pin drive; only the ON phase pulls one anode low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an          <= '1;
         r_seg         <= 7'h7F;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_slot_last && (r_idx == c_IDX_LAST);
         if (w_phase == PH_ON) begin
            r_an  <= ~(DIGITS'(1) << r_idx);
            r_seg <= w_seg_sel;
         end else begin
            r_an  <= '1;
            r_seg <= 7'h7F;
         end
      end
   end

   assign io_bus.an          = r_an;
   assign io_bus.seg         = r_seg;
   assign io_bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexing scan controller for a physical multi-digit seven-segment display with shared segment lines and per-digit anodes. It consumes the parallel per-digit segment patterns held by the MMIO seven-segment register bank and drives one digit at a time. Each digit slot gets a dead-time blanking interval to suppress ghosting, followed by a PWM on-window for brightness control. It sits between the display register bank and the board pins.

Parameters:
DIGITS, 8, number of digits scanned; index width is clog2(DIGITS), minimum 1 bit.
SCAN_DIV, 50000, clock cycles per digit slot; must be greater than DEAD.
DEAD, 64, blanking cycles at the start of every slot; must be at least 1.
(SCAN_DIV-DEAD) must be divisible by 16. STEP = (SCAN_DIV-DEAD)/16.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset, synchronous, active-high.
sevenseg  in  7*DIGITS  segment patterns, active-low; digit i uses bits [7i+6:7i].
digit_en  in  DIGITS  per-digit enable; 0 = digit i stays dark for its slot.
brightness  in  4  duty level 0..15; 15 = full on-window.
an  out  DIGITS  anode drive, active-low, at most one bit low.
seg  out  7  segment drive, active-low.
frame_start  out  1  one-cycle pulse each time the scan wraps back to digit 0.

Behaviour:
- Reset: cnt=0, idx=0, bright_q=0, an=all 1s, seg=7'b1111111, frame_start=0. A reset mid-slot abandons the slot and the next slot starts at digit 0.
- Slot counter cnt runs 0..SCAN_DIV-1 and increments every cycle.
  - At cnt==SCAN_DIV-1: cnt goes to 0 and idx advances; idx wraps from DIGITS-1 to 0.
- bright_q latches brightness when cnt==0. A brightness change mid-slot takes effect in the next slot.
- Phase decode (combinational from cnt, idx, bright_q):
  - BLANK: cnt < DEAD.
  - ON: DEAD <= cnt < DEAD + (bright_q+1)*STEP, and digit_en[idx]==1.
  - OFF: everything else, including any slot where digit_en[idx]==0.
- Outputs are registered with one-cycle latency from the phase:
  - ON: an = ~(1<<idx); seg = sevenseg[7idx+6:7idx], sampled live.
  - BLANK or OFF: an = all 1s; seg = 7'b1111111.
- Never more than one anode low. An anode is never low in the cycle after a BLANK-phase cycle.
- digit_en is sampled every cycle. Clearing a bit mid-ON darkens outputs on the next edge. A disabled digit still consumes its full slot, so the refresh rate is constant.
- frame_start is registered high for exactly the one cycle after the edge where idx wraps DIGITS-1 to 0. It is 0 at all other times, including after reset.
- Width rule: (bright_q+1)*STEP is evaluated at clog2(SCAN_DIV)+1 bits with no truncation.

Test Plan:
Cycle numbering for all scenarios: edge n = n-th rising edge after rst falls. After edge n, cnt = n mod SCAN_DIV.

1. DIGITS=4, SCAN_DIV=36, DEAD=4, brightness=15, digit_en=4'hF, sevenseg digit0=7'h40, digit1=7'h79 -> edges 1-4: an=4'hF, seg=7'h7F. Edges 5-36: an=4'hE, seg=7'h40. Edges 37-40: blank. Edges 41-72: an=4'hD, seg=7'h79.
2. Same setup, brightness=3 -> digit0 on for edges 5-12 only (8 cycles). Edges 13-40 have an=4'hF.
3. Same setup, full run -> frame_start high only after edge 144, then after edge 288. The an low bit rotates 0,1,2,3,0. At most one an bit is low in every cycle.
4. digit_en=4'b1101 -> during digit1's slot (edges 37-72), an=4'hF and seg=7'h7F. Digit2 is on from edge 77, unaffected.
5. brightness changed 15->0 at edge 10 -> digit0 stays full-width to edge 36. Digit1 is on for edges 41-42 only.
6. rst asserted for one edge at edge 50 (during digit1 ON) -> after that edge an=4'hF, seg=7'h7F, frame_start=0. After release, digit0 is blank for 4 edges, then on.
